addsub_result_stage: RTL and testbench
======================================

ADDSUB_RESULT_STAGE -- requirements
Module: addsub_result_stage

Interface
REQ-001 The block SHALL have one clock and one reset: clock `clk`, reset `rst`, asynchronous, active-high.
REQ-002 Port list, in order:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  upstream adder-subtractor result valid
- in_ready  out  1  stage can accept an entry
- a  in  4  operand A presented to the adder-subtractor
- b  in  4  operand B presented to the adder-subtractor
- mode  in  1  0 = add, 1 = subtract (A - B)
- s  in  4  sum/difference produced upstream
- cout  in  1  carry-out produced upstream
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- res  out  4  registered result (captured s)
- flag_c  out  1  add: carry; subtract: borrow
- flag_z  out  1  res == 0
- flag_n  out  1  res[3]
- flag_v  out  1  signed (two's-complement) overflow
- flag_err  out  1  upstream result disagrees with reference computation
- err_cnt  out  8  saturating count of accepted entries with flag_err = 1

Function
REQ-003 Storage SHALL be a 2-entry FIFO of {res, flag_c, flag_z, flag_n, flag_v, flag_err}; flags computed at push time from the same-cycle inputs.
REQ-004 Push SHALL occur on a rising edge when in_valid && in_ready; pop when out_valid && out_ready.
REQ-005 in_ready SHALL be 1 iff occupancy < 2, derived from registered state only (no combinational path from out_ready).
REQ-006 out_valid SHALL be 1 iff occupancy > 0; res and flag outputs SHALL show the head entry, and their values are don't-care while out_valid = 0.
REQ-007 Latency: an entry pushed into an empty FIFO SHALL appear at the outputs with out_valid = 1 in the following cycle.
REQ-008 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry becoming the head.
REQ-009 At occupancy 2, in_ready = 0, so no push occurs; a pop in that cycle SHALL reduce occupancy to 1.
REQ-010 Entries SHALL leave in acceptance order; head outputs SHALL hold stable while out_valid && !out_ready.
REQ-011 Reference computation: {ec, es} = a + (b XOR {4{mode}}) + mode, a 5-bit sum.
REQ-012 flag_err SHALL be 1 iff s != es or cout != ec.
REQ-013 flag_c SHALL equal cout when mode = 0 and ~cout when mode = 1.
REQ-014 flag_v SHALL be 1 when mode = 0 and a[3] == b[3] and s[3] != a[3].
REQ-015 flag_v SHALL be 1 when mode = 1 and a[3] != b[3] and s[3] != a[3]; otherwise flag_v SHALL be 0.
REQ-016 flag_z and flag_n SHALL be computed from the captured s, not from es.
REQ-017 err_cnt SHALL increment by 1 on each push with flag_err = 1 and saturate at 255; it is not affected by pops.

Reset
REQ-018 While rst = 1: occupancy = 0, out_valid = 0, in_ready = 1, err_cnt = 0.
REQ-019 While rst = 1: res and all flag outputs = 0.
REQ-020 Reset asserted mid-operation SHALL discard all stored entries immediately (asynchronously).
REQ-021 The first push SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-022 Add with signed overflow: a=5, b=3, mode=0, s=8, cout=0, out_ready=1 -> next cycle res=8, c=0, z=0, n=1, v=1, err=0.
REQ-023 Subtract to zero: a=3, b=3, mode=1, s=0, cout=1 -> res=0, c(borrow)=0, z=1, n=0, v=0, err=0.
REQ-024 Subtract with borrow: a=2, b=5, mode=1, s=13, cout=0 -> res=13, c=1, n=1, v=0, err=0.
REQ-025 Corrupt upstream: a=1, b=1, mode=0, s=3, cout=0 -> err=1 and err_cnt 0 -> 1; repeat 300 times -> err_cnt holds at 255.
REQ-026 Backpressure: out_ready=0, offer 3 valid entries back-to-back.
- in_ready drops after 2 accepted; third held until out_ready=1.
- Entries then drain in order, one per cycle.
- Push+pop at occupancy 1 keeps out_valid continuously high.
REQ-027 Reset mid-operation: pulse rst with occupancy 2 and err_cnt=4 -> out_valid=0, in_ready=1, err_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/addsub_result_stage.sv
// Result stage for a 4-bit adder-subtractor: derives status flags, cross-checks the
// upstream result against a local reference, and buffers entries in a 2-deep FIFO.
module addsub_result_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    input  logic [3:0] s,
    input  logic       cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] res,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v,
    output logic       flag_err,
    output logic [7:0] err_cnt
);

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       err;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       push;
    logic       pop;
    logic [4:0] ref_sum;
    entry_t     new_entry;
    entry_t     head;

    // Flags are derived from the captured s; the reference sum is used only for the error check.
    always_comb begin
        ref_sum       = {1'b0, a} + {1'b0, b ^ {4{mode}}} + {4'b0000, mode};
        new_entry.res = s;
        new_entry.c   = cout ^ mode;
        new_entry.z   = (s == 4'd0);
        new_entry.n   = s[3];
        new_entry.v   = mode ? ((a[3] != b[3]) && (s[3] != a[3]))
                             : ((a[3] == b[3]) && (s[3] != a[3]));
        new_entry.err = (s != ref_sum[3:0]) || (cout != ref_sum[4]);
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ~wr_ptr_q;
            if (new_entry.err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset as well, because the head outputs must read zero during reset.
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            err_cnt_q <= 8'd0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign res      = head.res;
    assign flag_c   = head.c;
    assign flag_z   = head.z;
    assign flag_n   = head.n;
    assign flag_v   = head.v;
    assign flag_err = head.err;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Self-checking bench for addsub_result_stage: directed cases plus randomized traffic
// compared against a queue-based arithmetic model.
module tb_addsub_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b, s;
    logic       mode, cout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] res;
    logic       flag_c, flag_z, flag_n, flag_v, flag_err;
    logic [7:0] err_cnt;

    addsub_result_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_err  (flag_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit c, z, n, v, err;
    } exp_t;

    exp_t q[$];
    int   err_exp = 0;
    int   errors  = 0;
    int   checks  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model written from the arithmetic meaning of add/subtract, not from the carry chain.
    function automatic exp_t model(input int ai, input int bi, input bit m, input int si, input bit ci);
        exp_t e;
        int   es;
        bit   ec, sa, sb, ss;
        if (!m) begin
            es = (ai + bi) % 16;
            ec = (ai + bi) >= 16;
        end else begin
            es = (ai - bi + 16) % 16;
            ec = (ai >= bi);
        end
        sa = ai >= 8;
        sb = bi >= 8;
        ss = si >= 8;
        e.res = si;
        e.c   = m ? !ci : ci;
        e.z   = (si == 0);
        e.n   = ss;
        e.v   = m ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        e.err = (si != es) || (ci != ec);
        return e;
    endfunction

    function automatic logic [8:0] pack(input exp_t e);
        logic [3:0] r;
        r = 4'(e.res);
        return {r, e.c, e.z, e.n, e.v, e.err};
    endfunction

    task automatic drive(input bit v, input int ai, input int bi, input bit m, input int si, input bit ci);
        in_valid = v;
        a        = 4'(ai);
        b        = 4'(bi);
        mode     = m;
        s        = 4'(si);
        cout     = ci;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, (q.size() < 2));
        check({tag, "_out_valid"}, out_valid, (q.size() > 0));
        check({tag, "_err_cnt"}, err_cnt, err_exp);
        if (q.size() > 0) begin
            check({tag, "_head"}, {res, flag_c, flag_z, flag_n, flag_v, flag_err}, pack(q[0]));
        end
    endtask

    // Checks outputs, then advances one clock and updates the model.
    task automatic cycle(input string tag);
        bit   do_push, do_pop;
        exp_t e;
        check_outputs(tag);
        do_push = (in_valid === 1'b1) && (q.size() < 2);
        do_pop  = (out_ready === 1'b1) && (q.size() > 0);
        e = model(int'(a), int'(b), mode, int'(s), cout);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(e);
            if (e.err && err_exp < 255) err_exp++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_res_flags"}, {res, flag_c, flag_z, flag_n, flag_v, flag_err}, 0);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        err_exp = 0;
        rst     = 1'b0;
    endtask

    initial begin
        int   idx;
        int   obs_order[$];
        int   ea[3] = '{1, 4, 7};
        int   eb[3] = '{1, 4, 1};
        bit   em[3] = '{0, 0, 1};
        int   es[3] = '{3, 8, 6};
        bit   ec[3] = '{0, 0, 1};
        bit   pw;

        rst       = 1'b1;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Signed-overflow add; pushed on the first edge after reset release.
        out_ready = 1'b1;
        drive(1, 5, 3, 0, 8, 0);
        cycle("add_ovf_push");
        in_valid = 1'b0;
        check("add_ovf_valid", out_valid, 1);
        check("add_ovf_head", {res, flag_c, flag_z, flag_n, flag_v, flag_err}, {4'd8, 5'b00110});
        cycle("add_ovf_pop");

        drive(1, 3, 3, 1, 0, 1);
        cycle("sub_zero_push");
        in_valid = 1'b0;
        check("sub_zero_head", {res, flag_c, flag_z, flag_n, flag_v, flag_err}, {4'd0, 5'b01000});
        cycle("sub_zero_pop");

        drive(1, 2, 5, 1, 13, 0);
        cycle("sub_borrow_push");
        in_valid = 1'b0;
        check("sub_borrow_head", {res, flag_c, flag_n, flag_v, flag_err}, {4'd13, 4'b1100});
        cycle("sub_borrow_pop");

        // Build occupancy 2 with err_cnt 4, then reset asynchronously.
        out_ready = 1'b0;
        drive(1, 1, 1, 0, 3, 0);
        cycle("pre_rst_fill0");
        cycle("pre_rst_fill1");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle("pre_rst_drain0");
        cycle("pre_rst_drain1");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cycle("pre_rst_fill2");
        cycle("pre_rst_fill3");
        in_valid = 1'b0;
        check("pre_rst_occ2", in_ready, 0);
        check("pre_rst_cnt4", err_cnt, 4);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        q.delete();
        err_exp = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Corrupt upstream: counter steps to 1 then saturates at 255.
        out_ready = 1'b1;
        drive(1, 1, 1, 0, 3, 0);
        cycle("corrupt_first");
        check("corrupt_err_flag", flag_err, 1);
        check("corrupt_cnt1", err_cnt, 1);
        for (int i = 1; i < 300; i++) cycle("corrupt_loop");
        in_valid = 1'b0;
        cycle("corrupt_tail");
        check("corrupt_sat", err_cnt, 255);

        // Backpressure: three entries offered while downstream is stalled.
        apply_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, ea[idx], eb[idx], em[idx], es[idx], ec[idx]);
            pw = (q.size() < 2);
            cycle("bp_fill");
            if (pw) idx++;
        end
        check("bp_full_in_ready", in_ready, 0);
        check("bp_head_stable", res, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && obs_order.size() < 3; i++) begin
            check("bp_valid_cont", out_valid, 1);
            if (out_valid === 1'b1) obs_order.push_back(int'(res));
            if (idx < 3) drive(1, ea[idx], eb[idx], em[idx], es[idx], ec[idx]);
            else in_valid = 1'b0;
            pw = (in_valid === 1'b1) && (q.size() < 2);
            cycle("bp_drain");
            if (pw) idx++;
        end
        check("bp_drained", obs_order.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < obs_order.size()) check("bp_order", obs_order[i], es[i]);
        end
        in_valid = 1'b0;
        cycle("bp_empty");

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            int ai, bi, si;
            bit mi, ci;
            ai = int'($urandom_range(0, 15));
            bi = int'($urandom_range(0, 15));
            mi = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                si = mi ? (ai - bi + 16) % 16 : (ai + bi) % 16;
                ci = mi ? (ai >= bi) : ((ai + bi) >= 16);
            end else begin
                si = int'($urandom_range(0, 15));
                ci = 1'($urandom_range(0, 1));
            end
            drive(1'($urandom_range(0, 1)), ai, bi, mi, si, ci);
            out_ready = 1'($urandom_range(0, 1));
            cycle("rand");
        end
        in_valid = 1'b0;
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
